// File: rtl/ro_puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF controller.
package ro_puf_pkg;

    localparam int unsigned DEF_NUM_RO    = 16;
    localparam int unsigned DEF_SEL_W     = 4;
    localparam int unsigned DEF_RESP_BITS = 8;
    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_WINDOW    = 1024;
    localparam int unsigned DEF_SETTLE    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COUNT   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Bit offset of pair idx (A index) inside the challenge word; B follows at +sel_w.
    function automatic int unsigned pair_offset(input int unsigned idx, input int unsigned sel_w);
        return 2 * sel_w * idx;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one oscillator output and counts its rising edges, saturating at all-ones.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sat_c
);

    logic s1, s2, s3;
    logic rise_c;

    assign rise_c = s2 & ~s3;
    assign sat_c  = &count;

    // Synchronizer flops run freely; only the counter honours clr/en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            count <= '0;
        end else begin
            s1 <= ro;
            s2 <= s1;
            s3 <= s2;
            if (clr) begin
                count <= '0;
            end else if (en && rise_c && !sat_c) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_puf_controller.sv
// Sequences oscillator pairs named by the challenge and builds the response by
// comparing their edge counts over a fixed window.
module ro_puf_controller
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_RO    = DEF_NUM_RO,
    parameter int unsigned SEL_W     = DEF_SEL_W,
    parameter int unsigned RESP_BITS = DEF_RESP_BITS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned SETTLE    = DEF_SETTLE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic [NUM_RO-1:0]            ro_in,
    output logic [NUM_RO-1:0]            ro_en,
    output logic [NUM_RO-1:0]            ro_rst,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         response,
    output logic                         err
);

    localparam int unsigned CHAL_W  = RESP_BITS * 2 * SEL_W;
    localparam int unsigned PAIR_W  = 2 * SEL_W;
    localparam int unsigned IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RESP_BITS-1:0] resp_d;
    logic                 err_d, busy_d, done_d;
    logic [NUM_RO-1:0]    ro_en_d, ro_rst_d, sel_mask;
    logic [PAIR_W-1:0]    pair_c, pair_n;
    logic [SEL_W-1:0]     sel_a_c, sel_b_c;
    logic                 same_c, bit_c, cnt_clr_c, cnt_en_c;
    logic [CNT_W-1:0]     cnt_a, cnt_b;
    logic                 sat_a_c, sat_b_c;

    // Pair currently being measured drives the input mux and the compare.
    assign pair_c    = PAIR_W'(chal_q >> pair_offset(32'(idx_q), SEL_W));
    assign sel_a_c   = pair_c[SEL_W-1:0];
    assign sel_b_c   = pair_c[PAIR_W-1:SEL_W];
    assign same_c    = (sel_a_c == sel_b_c);
    assign bit_c     = !same_c && (cnt_a > cnt_b);
    assign cnt_clr_c = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign cnt_en_c  = (state_q == ST_COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk(clk), .rst(rst), .ro(ro_in[sel_a_c]), .clr(cnt_clr_c), .en(cnt_en_c),
        .count(cnt_a), .sat_c(sat_a_c)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk(clk), .rst(rst), .ro(ro_in[sel_b_c]), .clr(cnt_clr_c), .en(cnt_en_c),
        .count(cnt_b), .sat_c(sat_b_c)
    );

    // Next state plus the output values for that state, registered below.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chal_d  = chal_q;
        timer_d = timer_q;
        resp_d  = response;
        err_d   = err;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    idx_d   = '0;
                    resp_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_d = TMR_W'(SETTLE - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    timer_d = TMR_W'(WINDOW - 1);
                    state_d = ST_COUNT;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (timer_q == '0) begin
                    state_d = ST_COMPARE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_COMPARE: begin
                resp_d  = response | (RESP_BITS'(bit_c) << idx_q);
                err_d   = err | same_c | sat_a_c | sat_b_c;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == IDX_W'(RESP_BITS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        pair_n   = PAIR_W'(chal_d >> pair_offset(32'(idx_d), SEL_W));
        sel_mask = (NUM_RO'(1) << pair_n[SEL_W-1:0]) | (NUM_RO'(1) << pair_n[PAIR_W-1:SEL_W]);
        ro_en_d  = ((state_d == ST_SETTLE) || (state_d == ST_COUNT)) ? sel_mask : '0;
        ro_rst_d = (state_d == ST_LOAD) ? sel_mask : '0;
        busy_d   = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            chal_q   <= '0;
            timer_q  <= '0;
            response <= '0;
            err      <= 1'b0;
            ro_en    <= '0;
            ro_rst   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            chal_q   <= chal_d;
            timer_q  <= timer_d;
            response <= resp_d;
            err      <= err_d;
            ro_en    <= ro_en_d;
            ro_rst   <= ro_rst_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: square-wave oscillator models against a period-based reference.
module tb_ro_puf_controller;
    import ro_puf_pkg::*;

    localparam int W_F   = 1024;
    localparam int L_F   = 1024 + 8 + 3;
    localparam int DONE_F = 8 * L_F + 1;
    localparam int W_S   = 64;
    localparam int DONE_S = 64 + 8 + 3 + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Oscillator i is a square wave with half period half[i] clk cycles, gated by its enable.
    int          tick = 0;
    int          half [16];
    logic [15:0] wave;
    always @(negedge clk) tick <= tick + 1;
    always_comb for (int i = 0; i < 16; i++) wave[i] = ((tick / half[i]) % 2) == 1;

    logic        start_f, start_s, start_t;
    logic [63:0] chal_f;
    logic [7:0]  chal_s, chal_t;
    logic [15:0] ro_in_f, en_f, rr_f, ro_in_s, en_s, rr_s, ro_in_t, en_t, rr_t;
    logic        busy_f, done_f, err_f, busy_s, done_s, err_s, busy_t, done_t, err_t;
    logic [7:0]  resp_f;
    logic [0:0]  resp_s, resp_t;

    assign ro_in_f = wave & en_f;
    assign ro_in_s = wave & en_s;
    assign ro_in_t = wave & en_t;

    ro_puf_controller u_full (
        .clk(clk), .rst(rst), .start(start_f), .challenge(chal_f), .ro_in(ro_in_f),
        .ro_en(en_f), .ro_rst(rr_f), .busy(busy_f), .done(done_f), .response(resp_f), .err(err_f)
    );
    ro_puf_controller #(.RESP_BITS(1), .WINDOW(W_S)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .challenge(chal_s), .ro_in(ro_in_s),
        .ro_en(en_s), .ro_rst(rr_s), .busy(busy_s), .done(done_s), .response(resp_s), .err(err_s)
    );
    ro_puf_controller #(.RESP_BITS(1), .WINDOW(W_S), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start_t), .challenge(chal_t), .ro_in(ro_in_t),
        .ro_en(en_t), .ro_rst(rr_t), .busy(busy_t), .done(done_t), .response(resp_t), .err(err_t)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic get_done(input int which);
        case (which)
            0:       return done_f;
            1:       return done_s;
            default: return done_t;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0:       return busy_f;
            1:       return busy_s;
            default: return busy_t;
        endcase
    endfunction

    function automatic logic get_err(input int which);
        case (which)
            0:       return err_f;
            1:       return err_s;
            default: return err_t;
        endcase
    endfunction

    function automatic logic [7:0] get_resp(input int which);
        case (which)
            0:       return resp_f;
            1:       return {7'd0, resp_s};
            default: return {7'd0, resp_t};
        endcase
    endfunction

    function automatic logic [15:0] get_en(input int which);
        case (which)
            0:       return en_f;
            1:       return en_s;
            default: return en_t;
        endcase
    endfunction

    function automatic logic [15:0] get_rr(input int which);
        case (which)
            0:       return rr_f;
            1:       return rr_s;
            default: return rr_t;
        endcase
    endfunction

    task automatic drive(input int which, input logic s, input logic [63:0] c);
        case (which)
            0:       begin start_f = s; chal_f = c; end
            1:       begin start_s = s; chal_s = c[7:0]; end
            default: begin start_t = s; chal_t = c[7:0]; end
        endcase
    endtask

    function automatic int sel_of(input logic [63:0] c, input int bit_i, input int side);
        logic [63:0] sh;
        sh = c >> (8 * bit_i + 4 * side);
        return int'(sh[3:0]);
    endfunction

    function automatic logic [15:0] pair_mask(input logic [63:0] c, input int bit_i);
        logic [15:0] one;
        one = 16'h0001;
        return (one << sel_of(c, bit_i, 0)) | (one << sel_of(c, bit_i, 1));
    endfunction

    // Expected edges in a window are window / period; a counter of cw bits saturates at 2^cw-1.
    function automatic bit will_sat(input int ro, input int w, input int cw);
        return (w / (2 * half[ro])) >= ((1 << cw) - 1);
    endfunction

    // Faster oscillator (shorter period) wins; same index gives 0 and flags err.
    task automatic model(input logic [63:0] c, input int rb, input int w, input int cw,
                         output logic [7:0] resp, output logic e);
        int a, b;
        resp = '0;
        e    = 1'b0;
        for (int i = 0; i < rb; i++) begin
            a = sel_of(c, i, 0);
            b = sel_of(c, i, 1);
            resp[i] = (a != b) && (half[a] < half[b]);
            if (a == b || will_sat(a, w, cw) || will_sat(b, w, cw)) e = 1'b1;
        end
    endtask

    // Starts one run and watches it for budget cycles; cycle 1 is the first after the accepting edge.
    task automatic run_dut(input int which, input logic [63:0] c, input int budget, input bit poke,
                           output int done_cyc, output int n_done,
                           output logic [15:0] rr1, output logic [15:0] en5, output logic [15:0] en40);
        @(negedge clk);
        drive(which, 1'b1, c);
        @(negedge clk);
        drive(which, 1'b0, c);
        done_cyc = -1;
        n_done   = 0;
        rr1 = '0; en5 = '0; en40 = '0;
        for (int cy = 1; cy <= budget; cy++) begin
            if (get_done(which)) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cy;
            end
            if (cy == 1)  rr1  = get_rr(which);
            if (cy == 5)  en5  = get_en(which);
            if (cy == 40) en40 = get_en(which);
            if (poke && cy < budget - 100 && (cy % 613) == 7)
                drive(which, 1'b1, {$urandom, $urandom});
            else
                drive(which, 1'b0, poke ? {$urandom, $urandom} : c);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b0, '0); drive(1, 1'b0, '0); drive(2, 1'b0, '0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({get_busy(k), get_done(k), get_err(k), get_resp(k), get_en(k), get_rr(k)} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d busy=%b done=%b err=%b resp=%h en=%h rst=%h, all must be 0",
                         k, get_busy(k), get_done(k), get_err(k), get_resp(k), get_en(k), get_rr(k));
            end
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_f !== 1'b0 || en_f !== 16'h0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b ro_en=%h, required 0/0000", busy_f, en_f);
        end
    endtask

    task automatic test_basic_pair();
        logic [63:0] c;
        logic [7:0]  er;
        logic        ee;
        int          dc, nd;
        logic [15:0] r1, e5, e40;
        half[3] = 2;
        half[7] = 3;
        for (int sw = 0; sw < 2; sw++) begin
            c = (sw == 0) ? 64'h73 : 64'h37;
            model(c, 1, W_S, 16, er, ee);
            run_dut(1, c, DONE_S + 5, 1'b0, dc, nd, r1, e5, e40);
            checks++;
            if (dc !== DONE_S || nd !== 1) begin
                errors++;
                $display("FAIL basic_done_cycle chal=%h got cycle %0d count %0d, required cycle %0d count 1", c[7:0], dc, nd, DONE_S);
            end
            checks++;
            if (resp_s !== er[0:0] || err_s !== ee) begin
                errors++;
                $display("FAIL basic_response chal=%h got resp=%b err=%b, required resp=%b err=%b", c[7:0], resp_s, err_s, er[0], ee);
            end
            checks++;
            if (r1 !== pair_mask(c, 0) || e5 !== pair_mask(c, 0) || e40 !== pair_mask(c, 0) || busy_s !== 1'b0) begin
                errors++;
                $display("FAIL basic_enables chal=%h got rst1=%h en5=%h en40=%h busy=%b, required %h/%h/%h busy 0",
                         c[7:0], r1, e5, e40, busy_s, pair_mask(c, 0), pair_mask(c, 0), pair_mask(c, 0));
            end
        end
    endtask

    task automatic test_tie_and_same();
        logic [63:0] c;
        logic [7:0]  er;
        logic        ee;
        int          dc, nd;
        logic [15:0] r1, e5, e40;
        half[1] = 3;
        half[2] = 3;
        half[5] = 2;
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? 64'h21 : 64'h55;
            model(c, 1, W_S, 16, er, ee);
            run_dut(1, c, DONE_S + 5, 1'b0, dc, nd, r1, e5, e40);
            checks++;
            if (resp_s !== er[0:0] || err_s !== ee || dc !== DONE_S) begin
                errors++;
                $display("FAIL tie_same chal=%h got resp=%b err=%b done@%0d, required resp=%b err=%b done@%0d",
                         c[7:0], resp_s, err_s, dc, er[0], ee, DONE_S);
            end
            checks++;
            if (e5 !== pair_mask(c, 0) || e40 !== pair_mask(c, 0)) begin
                errors++;
                $display("FAIL tie_same_enable chal=%h got en5=%h en40=%h, required %h", c[7:0], e5, e40, pair_mask(c, 0));
            end
        end
    endtask

    task automatic test_saturation();
        logic [63:0] c;
        logic [7:0]  er;
        logic        ee;
        int          dc, nd;
        logic [15:0] r1, e5, e40;
        half[2] = 1;
        half[9] = 4;
        c = 64'h92;
        model(c, 1, W_S, 4, er, ee);
        run_dut(2, c, DONE_S + 5, 1'b0, dc, nd, r1, e5, e40);
        checks++;
        if (u_sat.u_cnt_a.count !== 4'd15) begin
            errors++;
            $display("FAIL sat_count got %0d, required 15", u_sat.u_cnt_a.count);
        end
        checks++;
        if (resp_t !== er[0:0] || err_t !== ee || dc !== DONE_S || nd !== 1) begin
            errors++;
            $display("FAIL sat_result got resp=%b err=%b done@%0d x%0d, required resp=%b err=%b done@%0d x1",
                     resp_t, err_t, dc, nd, er[0], ee, DONE_S);
        end
    endtask

    task automatic shuffle_halves();
        int j, t;
        for (int i = 0; i < 16; i++) half[i] = i + 1;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i));
            t = half[i]; half[i] = half[j]; half[j] = t;
        end
    endtask

    task automatic test_full_response(input int iter);
        logic [63:0] c;
        logic [7:0]  er;
        logic        ee;
        int          dc, nd;
        logic [15:0] r1, e5, e40;
        shuffle_halves();
        c = {$urandom, $urandom};
        if (iter == 0) c[11:8] = c[15:12];
        model(c, 8, W_F, 16, er, ee);
        run_dut(0, c, DONE_F + 5, 1'b1, dc, nd, r1, e5, e40);
        checks++;
        if (dc !== DONE_F || nd !== 1) begin
            errors++;
            $display("FAIL full_done_cycle iter=%0d got cycle %0d count %0d, required cycle %0d count 1", iter, dc, nd, DONE_F);
        end
        checks++;
        if (resp_f !== er || err_f !== ee) begin
            errors++;
            $display("FAIL full_response iter=%0d chal=%h got resp=%h err=%b, required resp=%h err=%b", iter, c, resp_f, err_f, er, ee);
        end
        checks++;
        if (r1 !== pair_mask(c, 0) || e40 !== pair_mask(c, 0) || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL full_enables iter=%0d got rst1=%h en40=%h busy=%b, required %h/%h busy 0",
                     iter, r1, e40, busy_f, pair_mask(c, 0), pair_mask(c, 0));
        end
    endtask

    task automatic test_mid_run_reset();
        localparam int RST_CYC = 3300;
        logic [63:0] c;
        logic [7:0]  er;
        logic        ee;
        int          dc, nd, stray;
        logic [15:0] r1, e5, e40;
        c = {$urandom, $urandom};
        stray = 0;
        @(negedge clk);
        drive(0, 1'b1, c);
        @(negedge clk);
        drive(0, 1'b0, c);
        for (int cy = 1; cy < RST_CYC; cy++) begin
            if (done_f) stray++;
            @(negedge clk);
        end
        checks++;
        if (en_f !== pair_mask(c, 3)) begin
            errors++;
            $display("FAIL midrst_pre_enable got %h, required %h", en_f, pair_mask(c, 3));
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (u_full.state_q !== ST_IDLE || en_f !== 16'h0 || busy_f !== 1'b0 || done_f !== 1'b0 || resp_f !== 8'h0) begin
            errors++;
            $display("FAIL midrst_abort got state=%0d en=%h busy=%b done=%b resp=%h, required IDLE/0000/0/0/00",
                     u_full.state_q, en_f, busy_f, done_f, resp_f);
        end
        rst = 1'b1;
        for (int cy = 0; cy < 50; cy++) begin
            if (done_f) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d done pulses, required 0", stray);
        end
        c = {$urandom, $urandom};
        model(c, 8, W_F, 16, er, ee);
        run_dut(0, c, DONE_F + 5, 1'b0, dc, nd, r1, e5, e40);
        checks++;
        if (dc !== DONE_F || nd !== 1 || resp_f !== er || err_f !== ee) begin
            errors++;
            $display("FAIL midrst_rerun got done@%0d x%0d resp=%h err=%b, required done@%0d x1 resp=%h err=%b",
                     dc, nd, resp_f, err_f, DONE_F, er, ee);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) half[i] = i + 1;
        test_reset();
        test_basic_pair();
        test_tie_and_same();
        test_saturation();
        test_full_response(0);
        test_full_response(1);
        test_mid_run_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
